// File: rtl/bit_serial_alu_sequencer_if.sv
// rtl/bit_serial_alu_sequencer_if.sv - control-unit and 1-bit ALU slice signals of the sequencer
interface bit_serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Overflow;
  logic             slice_a;
  logic             slice_b;
  logic             slice_Less;
  logic             slice_Ainvert;
  logic             slice_Binvert;
  logic             slice_CarryIn;
  logic [1:0]       slice_Operation;
  logic             slice_Result;
  logic             slice_CarryOut;

  // Environment side: control unit plus the external slice.
  modport master (
    output start, ALUControl, A, B, slice_Result, slice_CarryOut,
    input  busy, done, ALUResult, Zero, Overflow,
    input  slice_a, slice_b, slice_Less, slice_Ainvert, slice_Binvert,
    input  slice_CarryIn, slice_Operation
  );

  modport slave (
    input  start, ALUControl, A, B, slice_Result, slice_CarryOut,
    output busy, done, ALUResult, Zero, Overflow,
    output slice_a, slice_b, slice_Less, slice_Ainvert, slice_Binvert,
    output slice_CarryIn, slice_Operation
  );
endinterface

// File: rtl/bit_serial_alu_sequencer.sv
// rtl/bit_serial_alu_sequencer.sv - runs a full-width ALU op LSB-first through one external 1-bit slice
module bit_serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  bit_serial_alu_sequencer_if.slave bus
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             msb_ovf;

  function automatic logic is_legal(input logic [3:0] c);
    return (c == OP_AND) || (c == OP_OR) || (c == OP_ADD) ||
           (c == OP_SUB) || (c == OP_SLT) || (c == OP_NOR);
  endfunction

  function automatic logic binv_of(input logic [3:0] c);
    return (c == OP_SUB) || (c == OP_SLT) || (c == OP_NOR);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    msb_ovf  = carry_q ^ bus.slice_CarryOut;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_legal(bus.ALUControl)) begin
            state_d = S_RUN;
            a_d     = bus.A;
            b_d     = bus.B;
            op_d    = bus.ALUControl;
            idx_d   = '0;
            acc_d   = '0;
            carry_d = binv_of(bus.ALUControl);
          end else begin
            state_d  = S_DONE;
            result_d = '0;
            zero_d   = 1'b1;
            ovf_d    = 1'b0;
          end
        end
      end
      S_RUN: begin
        acc_d[idx_q] = bus.slice_Result;
        carry_d      = bus.slice_CarryOut;
        idx_d        = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH - 1)) begin
          state_d = S_DONE;
          idx_d   = '0;
          // SLT keeps only the sign of A-B, corrected when the subtraction overflowed.
          if (op_q == OP_SLT) begin
            result_d    = '0;
            result_d[0] = bus.slice_Result ^ msb_ovf;
          end else begin
            result_d = acc_d;
          end
          ovf_d  = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? msb_ovf : 1'b0;
          zero_d = (result_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy            = (state_q == S_RUN);
    bus.done            = (state_q == S_DONE);
    bus.ALUResult       = result_q;
    bus.Zero            = zero_q;
    bus.Overflow        = ovf_q;
    bus.slice_a         = 1'b0;
    bus.slice_b         = 1'b0;
    bus.slice_Less      = 1'b0;
    bus.slice_Ainvert   = 1'b0;
    bus.slice_Binvert   = 1'b0;
    bus.slice_CarryIn   = 1'b0;
    bus.slice_Operation = 2'b00;
    if (state_q == S_RUN) begin
      bus.slice_a       = a_q[idx_q];
      bus.slice_b       = b_q[idx_q];
      bus.slice_Ainvert = (op_q == OP_NOR);
      bus.slice_Binvert = binv_of(op_q);
      bus.slice_CarryIn = carry_q;
      if (op_q == OP_OR)
        bus.slice_Operation = 2'b01;
      else if ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT))
        bus.slice_Operation = 2'b10;
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_sequencer.sv
// tb/tb_bit_serial_alu_sequencer.sv - scoreboard bench with a behavioural 1-bit ALU slice
module tb_bit_serial_alu_sequencer;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  bit_serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  bit_serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Behavioural slice: operand inversion, AND/OR/adder/Less mux.
  logic sa, sb_bit;
  assign sa     = bus.slice_a ^ bus.slice_Ainvert;
  assign sb_bit = bus.slice_b ^ bus.slice_Binvert;
  assign bus.slice_CarryOut = (sa & sb_bit) | (sa & bus.slice_CarryIn) | (sb_bit & bus.slice_CarryIn);
  assign bus.slice_Result   = (bus.slice_Operation == 2'b00) ? (sa & sb_bit) :
                              (bus.slice_Operation == 2'b01) ? (sa | sb_bit) :
                              (bus.slice_Operation == 2'b10) ? (sa ^ sb_bit ^ bus.slice_CarryIn) :
                              bus.slice_Less;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.v = 1'b0;
    case (c)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        e.r = a + b;
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0110: begin
        e.r = a - b;
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0111: e.r = ($signed(a) < $signed(b)) ? W'(1) : '0;
      4'b1100: e.r = ~(a | b);
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic logic [8:0] slice_pins();
    return {bus.slice_a, bus.slice_b, bus.slice_Less, bus.slice_Ainvert,
            bus.slice_Binvert, bus.slice_CarryIn, bus.slice_Operation, 1'b0};
  endfunction

  // Called at a negedge; start is driven at once so consecutive calls are back to back.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    exp_t e;
    bus.start      = 1'b1;
    bus.ALUControl = c;
    bus.A          = a;
    bus.B          = b;
    sb.push_back(model(c, a, b));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.A          = $urandom;
    bus.B          = $urandom;
    bus.ALUControl = 4'($urandom);
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL done_timeout op=%b: no done within %0d cycles", c, lat);
      sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.ALUResult !== e.r) begin
        errors++;
        $display("FAIL result op=%b a=%h b=%h: got %h expected %h", c, a, b, bus.ALUResult, e.r);
      end
      checks++;
      if ({bus.Zero, bus.Overflow} !== {e.z, e.v}) begin
        errors++;
        $display("FAIL flags op=%b: got Z=%b V=%b expected Z=%b V=%b", c, bus.Zero, bus.Overflow, e.z, e.v);
      end
      checks++;
      if (slice_pins() !== 9'd0) begin
        errors++;
        $display("FAIL slice_idle_at_done op=%b: got %b expected 0", c, slice_pins());
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse op=%b: got done=%b busy=%b expected 0 0", c, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.ALUControl = 4'b0;
    bus.A          = '0;
    bus.B          = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.ALUResult, bus.Zero, bus.Overflow, slice_pins()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h Z=%b V=%b pins=%b expected all 0",
               bus.busy, bus.done, bus.ALUResult, bus.Zero, bus.Overflow, slice_pins());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_ovf();
    int lat;
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL add_latency: got %0d expected %0d", lat, W + 1);
    end
    checks++;
    if ({bus.ALUResult, bus.Overflow, bus.Zero} !== {32'h8000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_ovf_const: got res=%h V=%b Z=%b expected 80000000 1 0",
               bus.ALUResult, bus.Overflow, bus.Zero);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(4'b0110, 32'd5, 32'd5, lat);
    checks++;
    if ({bus.ALUResult, bus.Zero, bus.Overflow} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_5_5: got res=%h Z=%b V=%b expected 0 1 0", bus.ALUResult, bus.Zero, bus.Overflow);
    end
    run_op(4'b0110, 32'd0, 32'd1, lat);
    checks++;
    if ({bus.ALUResult, bus.Overflow} !== {32'hFFFF_FFFF, 1'b0}) begin
      errors++;
      $display("FAIL sub_0_1: got res=%h V=%b expected ffffffff 0", bus.ALUResult, bus.Overflow);
    end
  endtask

  task automatic test_slt();
    int lat;
    logic [W-1:0] av[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    logic [W-1:0] bv[3] = '{32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] rv[3] = '{32'h1, 32'h1, 32'h0};
    for (int i = 0; i < 3; i++) begin
      run_op(4'b0111, av[i], bv[i], lat);
      checks++;
      if (bus.ALUResult !== rv[i]) begin
        errors++;
        $display("FAIL slt_%0d: got %h expected %h", i, bus.ALUResult, rv[i]);
      end
    end
  endtask

  task automatic test_logic();
    int lat;
    run_op(4'b1100, 32'h0, 32'hF0F0_F0F0, lat);
    checks++;
    if (bus.ALUResult !== 32'h0F0F_0F0F) begin
      errors++;
      $display("FAIL nor: got %h expected 0f0f0f0f", bus.ALUResult);
    end
    run_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
    checks++;
    if (bus.ALUResult !== 32'h0F00_0F00) begin
      errors++;
      $display("FAIL and: got %h expected 0f000f00", bus.ALUResult);
    end
    run_op(4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
    checks++;
    if (bus.ALUResult !== 32'hFFF0_FFF0) begin
      errors++;
      $display("FAIL or: got %h expected fff0fff0", bus.ALUResult);
    end
  endtask

  task automatic test_busy_ignored();
    int   ndone = 0;
    exp_t e;
    bus.start      = 1'b1;
    bus.ALUControl = 4'b0010;
    bus.A          = 32'd100;
    bus.B          = 32'd23;
    sb.push_back(model(4'b0010, 32'd100, 32'd23));
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.start      = (i % 3 == 0) && (i < 30);
      bus.ALUControl = 4'b0110;
      bus.A          = 32'd7;
      bus.B          = 32'd9;
      if (bus.done) begin
        ndone++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (bus.ALUResult !== e.r || bus.ALUResult !== 32'd123) begin
            errors++;
            $display("FAIL busy_result: got %h expected %h", bus.ALUResult, e.r);
          end
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d expected 1", ndone);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    int lat;
    bus.start      = 1'b1;
    bus.ALUControl = 4'b0010;
    bus.A          = 32'h1234_5678;
    bus.B          = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.ALUResult, bus.Zero, bus.Overflow, slice_pins()} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b res=%h Z=%b V=%b pins=%b expected all 0",
               bus.busy, bus.done, bus.ALUResult, bus.Zero, bus.Overflow, slice_pins());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d done pulses expected 0", ndone);
    end
    run_op(4'b0010, 32'd2, 32'd3, lat);
    checks++;
    if (bus.ALUResult !== 32'd5) begin
      errors++;
      $display("FAIL post_reset_add: got %h expected 5", bus.ALUResult);
    end
  endtask

  task automatic test_illegal();
    int lat;
    run_op(4'b1111, 32'hDEAD_BEEF, 32'h1, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL illegal_latency: got %0d expected 1", lat);
    end
    checks++;
    if ({bus.ALUResult, bus.Zero, bus.Overflow} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_result: got res=%h Z=%b V=%b expected 0 1 0", bus.ALUResult, bus.Zero, bus.Overflow);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [3:0] ops[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    for (int i = 0; i < 10; i++)
      run_op(ops[$urandom_range(0, 5)], $urandom, $urandom, lat);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_ovf();
    test_sub();
    test_slt();
    test_logic();
    test_busy_ignored();
    test_reset_mid_run();
    test_illegal();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
